// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts one instruction, decodes it, drives the ALU,
// then returns the captured result and branch decision.
module alu_sequencer #(
  parameter int unsigned EXEC_CYCLES   = 1,
  parameter bit          SHIFT_FROM_RS = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_sel,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_taken,
  output logic        rsp_illegal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    C_ALU,
    C_BEQ,
    C_BNE,
    C_ILL
  } cls_t;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t      state_q;
  cls_t        cls_q;
  logic [3:0]  cnt_q;
  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic [2:0]  alu_sel_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_result_q;
  logic        rsp_taken_q;
  logic        rsp_illegal_q;

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [31:0] shamt;
  logic [31:0] sext;
  logic [31:0] zext;
  logic [2:0]  sel_d;
  logic [31:0] a_d;
  logic [31:0] b_d;
  cls_t        cls_d;
  logic        unused_fields;

  assign op    = instr[31:26];
  assign fn    = instr[5:0];
  assign sext  = {{16{instr[15]}}, instr[15:0]};
  assign zext  = {16'h0, instr[15:0]};
  assign shamt = SHIFT_FROM_RS ? {27'b0, rs_val[4:0]}
                               : {27'b0, instr[10:6]};
  assign unused_fields = ^instr[25:16];

  always_comb begin
    sel_d = 3'b011;
    a_d   = rs_val;
    b_d   = rt_val;
    cls_d = C_ALU;
    unique case (1'b1)
      (op == 6'h00) && (fn == 6'h20): sel_d = 3'b010;
      (op == 6'h00) && (fn == 6'h22): sel_d = 3'b110;
      (op == 6'h00) && (fn == 6'h24): sel_d = 3'b000;
      (op == 6'h00) && (fn == 6'h25): sel_d = 3'b001;
      (op == 6'h00) && (fn == 6'h2A): sel_d = 3'b111;
      (op == 6'h00) && (fn == 6'h00): begin
        sel_d = 3'b100;
        a_d   = shamt;
      end
      (op == 6'h00) && (fn == 6'h02): begin
        sel_d = 3'b101;
        a_d   = shamt;
      end
      op == 6'h08: begin
        sel_d = 3'b010;
        b_d   = sext;
      end
      op == 6'h0A: begin
        sel_d = 3'b111;
        b_d   = sext;
      end
      op == 6'h0C: begin
        sel_d = 3'b000;
        b_d   = zext;
      end
      op == 6'h0D: begin
        sel_d = 3'b001;
        b_d   = zext;
      end
      op == 6'h04: begin
        sel_d = 3'b110;
        cls_d = C_BEQ;
      end
      op == 6'h05: begin
        sel_d = 3'b110;
        cls_d = C_BNE;
      end
      default: cls_d = C_ILL;
    endcase
  end

  // Operands/select change only on accept; reset drops any in-flight op
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cls_q         <= C_ALU;
      cnt_q         <= 4'd0;
      alu_a_q       <= 32'h0;
      alu_b_q       <= 32'h0;
      alu_sel_q     <= 3'b011;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= 32'h0;
      rsp_taken_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            state_q   <= S_EXEC;
            cls_q     <= cls_d;
            alu_sel_q <= sel_d;
            alu_a_q   <= a_d;
            alu_b_q   <= b_d;
            cnt_q     <= CNT_LOAD;
          end
        end
        S_EXEC: begin
          if (cnt_q == 4'd0) begin
            rsp_result_q  <= alu_out;
            rsp_taken_q   <= ((cls_q == C_BEQ) & alu_zero) |
                             ((cls_q == C_BNE) & ~alu_zero);
            rsp_illegal_q <= (cls_q == C_ILL);
            rsp_valid_q   <= 1'b1;
            state_q       <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_sel     = alu_sel_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_taken   = rsp_taken_q;
  assign rsp_illegal = rsp_illegal_q;

endmodule
